systolic_skew_feeder: RTL and testbench

- Upstream feeder for the tpumac systolic array.
- Accepts one DIM-wide vector of signed 8-bit operands per cycle through a valid/ready handshake.
- Emits the vector diagonally skewed: lane i is delayed i+1 cycles, so row/column i of the array sees its operand exactly when the neighbouring MAC's Aout/Bout arrives.
- After the last vector of a tile, it flushes zero bubbles until every lane has drained, then pulses done.

---
 rtl/tpu_pkg.sv | 17 +
 rtl/systolic_skew_feeder_lane.sv | 44 ++++
 rtl/systolic_skew_feeder.sv | 100 ++++++++++
 tb/tb_systolic_skew_feeder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared types and sizes for the tpumac systolic front-end.
package tpu_pkg;

   localparam int unsigned BITS_AB = 8;
   localparam int unsigned DIM     = 8;
   localparam int unsigned CNT_W   = 5;

   typedef logic signed [BITS_AB-1:0] op_t;
   typedef op_t vec_t [DIM];

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      FLUSH
   } feeder_state_t;

endpackage

// File: rtl/systolic_skew_feeder_lane.sv
// One diagonal lane: a DEPTH-stage delay chain carrying data plus a valid bit.
module skew_lane #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned BITS  = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [BITS-1:0] in_data,
   input  logic            in_valid,
   output logic [BITS-1:0] out_data,
   output logic            out_valid
);

   logic [DEPTH-1:0][BITS-1:0] data_q, data_d;
   logic [DEPTH-1:0]           vld_q, vld_d;

   always_comb begin
      data_d = data_q;
      vld_d  = vld_q;
      if (en) begin
         data_d[0] = in_data;
         vld_d[0]  = in_valid;
         for (int i = 1; i < int'(DEPTH); i++) begin
            data_d[i] = data_q[i-1];
            vld_d[i]  = vld_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
         vld_q  <= '0;
      end else begin
         data_q <= data_d;
         vld_q  <= vld_d;
      end
   end

   assign out_data  = data_q[DEPTH-1];
   assign out_valid = vld_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Diagonally skews DIM-wide operand vectors into the systolic array edge and
// flushes zero bubbles after the last vector of a tile before pulsing done.
module systolic_skew_feeder #(
   parameter int unsigned BITS_AB = tpu_pkg::BITS_AB,
   parameter int unsigned DIM     = tpu_pkg::DIM
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   in_valid,
   input  logic                   in_last,
   input  logic [DIM*BITS_AB-1:0] in_vec,
   output logic                   in_ready,
   output logic [DIM*BITS_AB-1:0] skew_out,
   output logic [DIM-1:0]         skew_valid,
   output logic                   busy,
   output logic                   done
);

   import tpu_pkg::*;

   feeder_state_t    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             accept;
   logic [DIM*BITS_AB-1:0] head_data;

   // done_q blocks acceptance for the IDLE cycle right after a tile completes
   assign in_ready = en & ~rst & ~done_q & ((state_q == IDLE) | (state_q == STREAM));
   assign accept   = in_valid & in_ready;

   always_comb begin
      head_data = '0;
      if (accept) head_data = in_vec;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      if (en) begin
         case (state_q)
            IDLE, STREAM: begin
               if (accept) begin
                  if (in_last) begin
                     state_d = FLUSH;
                     cnt_d   = CNT_W'(DIM);
                  end else begin
                     state_d = STREAM;
                  end
               end
            end
            FLUSH: begin
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign done = done_q;
   assign busy = busy_q;

   // lane i has i+1 stages so it trails lane i-1 by one cycle
   for (genvar i = 0; i < int'(DIM); i++) begin : g_lane
      skew_lane #(
         .DEPTH(i + 1),
         .BITS (BITS_AB)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .en       (en),
         .in_data  (head_data[i*BITS_AB +: BITS_AB]),
         .in_valid (accept),
         .out_data (skew_out[i*BITS_AB +: BITS_AB]),
         .out_valid(skew_valid[i])
      );
   end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder at DIM=4: directed table, corner sequences, random traffic.
module tb_systolic_skew_feeder;

   localparam int unsigned D = 4;
   localparam int unsigned B = 8;
   localparam int unsigned W = D * B;

   logic         clk = 1'b0;
   logic         rst, en, in_valid, in_last;
   logic [W-1:0] in_vec;
   logic         in_ready;
   logic [W-1:0] skew_out;
   logic [D-1:0] skew_valid;
   logic         busy, done;

   always #5 clk = ~clk;

   systolic_skew_feeder #(.BITS_AB(B), .DIM(D)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_vec    (in_vec),
      .in_ready  (in_ready),
      .skew_out  (skew_out),
      .skew_valid(skew_valid),
      .busy      (busy),
      .done      (done)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference: history of heads injected on advancing edges, newest first
   logic [W-1:0] m_data[$];
   logic         m_vld[$];
   int           m_adv;
   bit           m_flush, m_done, m_tile;
   logic         rdy_seen;

   typedef struct {
      logic         v, l, e;
      logic [W-1:0] vec;
      logic         rdy;
      logic [W-1:0] out;
      logic [D-1:0] vld;
      logic         busy, done;
   } vec_rec_t;

   vec_rec_t tbl[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] exp_out();
      logic [W-1:0] r = '0;
      for (int i = 0; i < int'(D); i++)
         if (i < m_data.size()) r[i*B +: B] = m_data[i][i*B +: B];
      return r;
   endfunction

   function automatic logic [D-1:0] exp_vld();
      logic [D-1:0] r = '0;
      for (int i = 0; i < int'(D); i++)
         if (i < m_vld.size()) r[i] = m_vld[i];
      return r;
   endfunction

   task automatic model_reset();
      m_data.delete();
      m_vld.delete();
      m_adv   = 0;
      m_flush = 0;
      m_done  = 0;
      m_tile  = 0;
   endtask

   task automatic step(input logic v, input logic l, input logic e, input logic [W-1:0] vec);
      logic exp_rdy, acc;
      in_valid = v; in_last = l; en = e; in_vec = vec;
      #1;
      exp_rdy  = e && !m_flush && !m_done && !rst;
      rdy_seen = in_ready;
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      acc = v && exp_rdy;
      @(posedge clk);
      if (e) begin
         m_data.push_front(acc ? vec : '0);
         m_vld.push_front(acc);
         if (m_data.size() > int'(D)) begin
            void'(m_data.pop_back());
            void'(m_vld.pop_back());
         end
         m_done = 0;
         if (m_flush) begin
            m_adv++;
            if (m_adv == int'(D)) begin
               m_done = 1; m_flush = 0; m_tile = 0;
            end
         end
         if (acc) begin
            m_tile = 1;
            if (l) begin m_flush = 1; m_adv = 0; end
         end
      end else begin
         m_done = 0;
      end
      #1;
      chk("skew_out",   64'(skew_out),   64'(exp_out()));
      chk("skew_valid", 64'(skew_valid), 64'(exp_vld()));
      chk("busy",       64'(busy),       64'(m_tile));
      chk("done",       64'(done),       64'(m_done));
   endtask

   task automatic do_reset(input int ncyc);
      rst = 1'b1;
      #1;
      chk("rst_in_ready",   64'(in_ready),   64'(0));
      chk("rst_skew_out",   64'(skew_out),   64'(0));
      chk("rst_skew_valid", 64'(skew_valid), 64'(0));
      chk("rst_busy_done",  64'({busy, done}), 64'(0));
      repeat (ncyc) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   function automatic logic [W-1:0] ramp_vec(input int j);
      logic [W-1:0] r;
      for (int i = 0; i < int'(D); i++) r[i*B +: B] = B'((j + 1) * i + 1);
      return r;
   endfunction

   initial begin
      rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_vec = '0;
      model_reset();
      do_reset(2);

      // Single vector {4,3,2,1} with last: expectations written out by hand
      tbl[0] = '{1'b1, 1'b1, 1'b1, 32'h04030201, 1'b1, 32'h00000001, 4'b0001, 1'b1, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 32'h00000200, 4'b0010, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 32'h00030000, 4'b0100, 1'b1, 1'b0};
      tbl[3] = '{1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 32'h04000000, 4'b1000, 1'b1, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 32'h00000000, 4'b0000, 1'b0, 1'b1};
      tbl[5] = '{1'b1, 1'b0, 1'b1, 32'h7f7f7f7f, 1'b0, 32'h00000000, 4'b0000, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 1'b1, 32'h0,        1'b1, 32'h00000000, 4'b0000, 1'b0, 1'b0};
      for (int r = 0; r < 7; r++) begin
         step(tbl[r].v, tbl[r].l, tbl[r].e, tbl[r].vec);
         chk($sformatf("tbl%0d_rdy", r),  64'(rdy_seen),   64'(tbl[r].rdy));
         chk($sformatf("tbl%0d_out", r),  64'(skew_out),   64'(tbl[r].out));
         chk($sformatf("tbl%0d_vld", r),  64'(skew_valid), 64'(tbl[r].vld));
         chk($sformatf("tbl%0d_bd", r),   64'({busy, done}), 64'({tbl[r].busy, tbl[r].done}));
      end

      // Back-to-back stream: full diagonal after the fourth vector
      for (int j = 0; j < 4; j++) step(1'b1, 1'b1 && (j == 3), 1'b1, ramp_vec(j));
      chk("stream_diag_out", 64'(skew_out),   64'(32'h04050401));
      chk("stream_diag_vld", 64'(skew_valid), 64'(4'b1111));
      repeat (6) step(1'b0, 1'b0, 1'b1, '0);

      // Stall for three cycles mid-stream and mid-flush
      step(1'b1, 1'b0, 1'b1, ramp_vec(0));
      step(1'b1, 1'b0, 1'b1, ramp_vec(1));
      repeat (3) step(1'b1, 1'b1, 1'b0, 32'hdeadbeef);
      step(1'b1, 1'b0, 1'b1, ramp_vec(2));
      step(1'b1, 1'b1, 1'b1, ramp_vec(3));
      step(1'b0, 1'b0, 1'b1, '0);
      repeat (3) step(1'b0, 1'b0, 1'b0, '0);
      repeat (6) step(1'b0, 1'b0, 1'b1, '0);

      // Bubble between v0 and v1, plus a stray in_last without in_valid
      step(1'b1, 1'b0, 1'b1, 32'h80ff017f);
      step(1'b0, 1'b1, 1'b1, 32'h11111111);
      chk("bubble_lane0", 64'(skew_valid), 64'(4'b0010));
      step(1'b1, 1'b1, 1'b1, 32'h01020304);
      repeat (6) step(1'b0, 1'b0, 1'b1, '0);

      // Random traffic with occasional mid-tile resets
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset(2);
         end else begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 5) != 0), W'($urandom));
         end
      end
      repeat (8) step(1'b0, 1'b0, 1'b1, '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
